// File: rtl/mul_pkg.sv
// Shared types and sizing for the iterative shift-add multiplier.
package mul_pkg;

  localparam int NBITS_DEF = 8;
  localparam int CNT_W     = $clog2(NBITS_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for an arbitrary operand width; never narrower than 1 bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_2n.sv
// Parameterised combinational adder used for the shift-add accumulate.
module add_2n #(
  parameter int W = 16
) (
  input  logic [W-1:0] in0,
  input  logic [W-1:0] in1,
  input  logic         cin,
  output logic         cout,
  output logic [W-1:0] sum
);

  assign {cout, sum} = in0 + in1 + {{W{1'b0}}, cin};

endmodule

// File: rtl/mul_8b_iter.sv
// Iterative shift-add unsigned multiplier: NBITS x NBITS -> 2*NBITS.
// Optional macro MUL_EARLY_EXIT_EN: leave CALC as soon as the remaining
// multiplier bits are all zero (same product, shorter latency).
module mul_8b_iter
  import mul_pkg::*;
#(
  parameter int NBITS = NBITS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               istream_val,
  output logic               istream_rdy,
  input  logic [NBITS-1:0]   in0,
  input  logic [NBITS-1:0]   in1,
  output logic               ostream_val,
  input  logic               ostream_rdy,
  output logic [2*NBITS-1:0] prod
);

  localparam int CW = cnt_width(NBITS);

  state_t               state, state_nx;
  logic [2*NBITS-1:0]   a_reg, result, sum;
  logic [NBITS-1:0]     b_reg;
  logic [CW-1:0]        count;
  logic                 last, b_zero, calc_done;
  logic                 cout_unused;

  // Final CALC edge is the one where count already holds NBITS-1.
  assign last = (count == CW'(NBITS - 1));

`ifdef MUL_EARLY_EXIT_EN
  // No multiplier bits left: further iterations cannot change the result.
  assign b_zero = (b_reg == '0);
`else
  assign b_zero = 1'b0;
`endif

  assign calc_done = last || b_zero;

  // Accumulate adder; 2*NBITS is always wide enough, so carry-out is dropped.
  add_2n #(.W(2*NBITS)) u_add (
    .in0  (result),
    .in1  (a_reg),
    .cin  (1'b0),
    .cout (cout_unused),
    .sum  (sum)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (istream_val) state_nx = CALC;
      CALC:    if (calc_done)   state_nx = DONE;
      DONE:    if (ostream_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    istream_rdy = (state == IDLE);
    ostream_val = (state == DONE);
  end

  // Datapath: load on accept, shift-add while calculating
  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      count  <= '0;
    end else begin
      case (state)
        IDLE: if (istream_val) begin
          a_reg  <= {{NBITS{1'b0}}, in0};
          b_reg  <= in1;
          result <= '0;
          count  <= '0;
        end
        CALC: if (!b_zero) begin
          if (b_reg[0]) result <= sum;
          a_reg <= a_reg << 1;
          b_reg <= b_reg >> 1;
          count <= count + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Product is the live accumulator; only meaningful while ostream_val is high.
  assign prod = result;

endmodule

// File: tb/tb_mul_8b_iter.sv
// Scoreboard bench for mul_8b_iter: directed boundary cases plus random
// operands with random output stalls. Latency expectations follow
// MUL_EARLY_EXIT_EN when it is defined.
module tb_mul_8b_iter;

  localparam int NB = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          istream_val;
  logic          istream_rdy;
  logic [NB-1:0] in0, in1;
  logic          ostream_val;
  logic          ostream_rdy;
  logic [2*NB-1:0] prod;

  logic dir_rdy, rnd_en, rnd_rdy;
  assign ostream_rdy = rnd_en ? rnd_rdy : dir_rdy;

  mul_8b_iter #(.NBITS(NB)) dut (
    .clk         (clk),
    .rst         (rst),
    .istream_val (istream_val),
    .istream_rdy (istream_rdy),
    .in0         (in0),
    .in1         (in1),
    .ostream_val (ostream_val),
    .ostream_rdy (ostream_rdy),
    .prod        (prod)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2*NB-1:0] p;
    int              lat;
    int              acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   seen = 0;
  bit   was_hs = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer product and cycles spent in CALC.
  function automatic logic [2*NB-1:0] exp_prod(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int r;
    r = int'(a) * int'(b);
    return r[2*NB-1:0];
  endfunction

  function automatic int exp_lat(input logic [NB-1:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int nb = 0;
    for (int i = 0; i < NB; i++) if (b[i]) nb = i + 1;
    return (nb + 1 < NB) ? nb + 1 : NB;
`else
    return NB;
`endif
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    rnd_rdy = ($urandom_range(0, 3) != 0);
  end

  // Monitor: samples at negedge, i.e. the values the next rising edge will see.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      seen   = 0;
      was_hs = 0;
    end else begin
      if (was_hs) begin
        chk("idle_after_hs_rdy", istream_rdy, 1);
        chk("idle_after_hs_val", ostream_val, 0);
      end
      was_hs = 0;
      chk("rdy_val_exclusive", istream_rdy & ostream_val, 0);
      if (ostream_val) begin
        if (q.size() == 0) begin
          chk("spurious_output", ostream_val, 0);
        end else begin
          if (!seen) begin
            chk("latency", cyc - q[0].acc, q[0].lat);
            seen = 1;
          end
          chk("prod", prod, q[0].p);
          if (ostream_rdy) begin
            void'(q.pop_front());
            seen   = 0;
            was_hs = 1;
          end
        end
      end else if (q.size() > 0 && (cyc - q[0].acc) > NB + 4) begin
        chk("output_timeout", cyc - q[0].acc, q[0].lat);
        void'(q.pop_front());
        seen = 0;
      end
      if (istream_val && istream_rdy) begin
        exp_t e;
        e.p   = exp_prod(in0, in1);
        e.lat = exp_lat(in1);
        e.acc = cyc + 1;
        q.push_back(e);
      end
    end
  end

  // Present operands until accepted; returns just after the accept edge.
  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b);
    int n;
    @(posedge clk); #1;
    istream_val = 1; in0 = a; in1 = b;
    n = 0;
    forever begin
      @(negedge clk);
      if (istream_rdy) break;
      n++;
      if (n > 100) begin
        chk("accept_timeout", istream_rdy, 1);
        break;
      end
    end
    @(posedge clk); #1;
    istream_val = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    forever begin
      @(negedge clk);
      if (istream_rdy && q.size() == 0) break;
      n++;
      if (n > 200) begin
        chk("idle_timeout", q.size(), 0);
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic [NB-1:0] a, b;
    rst = 1; istream_val = 0; in0 = '0; in1 = '0;
    dir_rdy = 1; rnd_en = 0;

    // Reset held for two edges
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_istream_rdy", istream_rdy, 1);
    chk("rst_ostream_val", ostream_val, 0);
    chk("rst_prod", prod, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_istream_rdy", istream_rdy, 1);
    chk("idle_ostream_val", ostream_val, 0);
    chk("idle_prod", prod, 0);

    // Basic and boundary operands
    do_op(8'd13, 8'd11);  wait_idle();
    do_op(8'hFF, 8'hFF);  wait_idle();
    do_op(8'hA5, 8'h00);  wait_idle();
    do_op(8'h80, 8'h01);  wait_idle();
    do_op(8'h01, 8'h80);  wait_idle();

    // Backpressure: product held, busy input ignored
    dir_rdy = 0;
    do_op(8'd7, 8'd6);
    n = 0;
    while (!ostream_val && n < 30) begin @(negedge clk); n++; end
    chk("bp_val_seen", ostream_val, 1);
    repeat (5) begin
      @(posedge clk); #1;
      istream_val = 1; in0 = 8'd9; in1 = 8'd9;
      chk("bp_istream_rdy", istream_rdy, 0);
      chk("bp_prod_held", prod, 16'd42);
    end
    istream_val = 0;
    dir_rdy = 1;
    wait_idle();

    // Reset on the 4th CALC cycle drops the pending result
    do_op(8'd200, 8'd3);
    repeat (3) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("midrst_istream_rdy", istream_rdy, 1);
    chk("midrst_ostream_val", ostream_val, 0);
    chk("midrst_prod", prod, 0);
    do_op(8'd2, 8'd2);    wait_idle();

    // Random operands with random output stalls
    rnd_en = 1;
    for (int i = 0; i < 200; i++) begin
      a = NB'($urandom);
      b = NB'($urandom);
      case ($urandom_range(0, 9))
        0: b = '0;
        1: a = '1;
        2: b = NB'(1) << $urandom_range(0, NB - 1);
        default: ;
      endcase
      do_op(a, b);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    wait_idle();
    rnd_en = 0;
    chk("queue_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
